// File: rtl/ccsds_turbo_enc_pkg.sv
// Shared bank-state type and width constants for the CCSDS turbo encoder
// information-bit buffering.
package ccsds_turbo_enc_pkg;

  localparam int K_MAX_DEF = 16384;
  localparam int AW_DEF    = $clog2(K_MAX_DEF);
  localparam int LW_DEF    = AW_DEF + 1;

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_READING
  } bank_state_t;

  // A bank can take write data while it is empty (claimable) or part-filled.
  function automatic logic bank_writable(input bank_state_t s);
    return (s == BANK_EMPTY) || (s == BANK_FILLING);
  endfunction

endpackage

// File: rtl/ccsds_turbo_sdpram.sv
// Simple dual-port RAM: one write port, one read port with a registered,
// enable-gated output that holds its value between reads.
module ccsds_turbo_sdpram #(
  parameter  int DEPTH = 32768,
  parameter  int DW    = 1,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!rstn)   rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/ccsds_turbo_enc_pingpong_buf.sv
// Ping-pong information-bit buffer: one bank fills from the serial input while
// the other is served to the RSC1 (natural) and RSC2 (interleaved) read ports.
module ccsds_turbo_enc_pingpong_buf
  import ccsds_turbo_enc_pkg::*;
#(
  parameter  int K_MAX = K_MAX_DEF,
  parameter  int DW    = 1,
  localparam int AW    = $clog2(K_MAX)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [AW:0]   i_blk_len,
  input  logic          i_wvalid,
  input  logic [DW-1:0] i_wdata,
  output logic          o_wready,
  output logic          o_wblk_done,
  output logic          o_rd_avail,
  input  logic          i_rd_start,
  output logic [AW:0]   o_rd_len,
  input  logic          i_read1,
  input  logic [AW-1:0] i_raddr1,
  input  logic          i_read2,
  input  logic [AW-1:0] i_raddr2,
  output logic [DW-1:0] o_rsc1_idata,
  output logic          o_rsc1_vld,
  output logic [DW-1:0] o_rsc2_idata,
  output logic          o_rsc2_vld,
  input  logic          i_rd_done,
  output logic          o_len_err
);

  bank_state_t   bank_st  [2];
  bank_state_t   bank_nxt [2];
  logic [AW:0]   bank_len [2];
  logic          wbank, wbank_nxt;
  logic          rbank, rbank_nxt;
  logic [AW-1:0] wcnt, wcnt_nxt;

  logic          reading, len_bad, wr_first, wr_fire, wr_last;
  logic          rd_claim, rd_release, rd_en1, rd_en2;
  logic [AW:0]   new_len, k_eff;
  logic [AW:0]   waddr, raddr1, raddr2;

  // Only the bank at rbank can ever be READING, so its state alone tells us
  // whether the read side is busy.
  always_comb begin
    reading    = (bank_st[rbank] == BANK_READING);
    len_bad    = (i_blk_len == '0) || (i_blk_len > (AW+1)'(K_MAX));
    new_len    = len_bad ? (AW+1)'(K_MAX) : i_blk_len;
    wr_first   = (bank_st[wbank] == BANK_EMPTY);
    k_eff      = wr_first ? new_len : bank_len[wbank];
    o_wready   = bank_writable(bank_st[wbank]);
    wr_fire    = i_wvalid && o_wready;
    wr_last    = ({1'b0, wcnt} == (k_eff - (AW+1)'(1)));
    o_rd_avail = (bank_st[rbank] == BANK_FULL) && !reading;
    rd_claim   = i_rd_start && o_rd_avail;
    rd_release = i_rd_done && reading;
    o_rd_len   = reading ? bank_len[rbank] : '0;
    rd_en1     = i_read1 && reading;
    rd_en2     = i_read2 && reading;

    wbank_nxt = wbank;
    rbank_nxt = rbank;
    wcnt_nxt  = wcnt;
    if (wr_fire) begin
      if (wr_last) begin
        wcnt_nxt  = '0;
        wbank_nxt = ~wbank;
      end else begin
        wcnt_nxt  = wcnt + AW'(1);
      end
    end
    if (rd_release) rbank_nxt = ~rbank;

    // Write, claim and release each touch a bank in a different state, so
    // they never conflict on the same bank within one cycle.
    for (int b = 0; b < 2; b++) begin
      bank_nxt[b] = bank_st[b];
      if (wr_fire && (wbank == 1'(b)))
        bank_nxt[b] = wr_last ? BANK_FULL : BANK_FILLING;
      if (rd_claim && (rbank == 1'(b)))
        bank_nxt[b] = BANK_READING;
      if (rd_release && (rbank == 1'(b)))
        bank_nxt[b] = BANK_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      bank_st[0]  <= BANK_EMPTY;
      bank_st[1]  <= BANK_EMPTY;
      bank_len[0] <= '0;
      bank_len[1] <= '0;
      wbank       <= 1'b0;
      rbank       <= 1'b0;
      wcnt        <= '0;
      o_wblk_done <= 1'b0;
      o_len_err   <= 1'b0;
      o_rsc1_vld  <= 1'b0;
      o_rsc2_vld  <= 1'b0;
    end else begin
      bank_st[0]  <= bank_nxt[0];
      bank_st[1]  <= bank_nxt[1];
      wbank       <= wbank_nxt;
      rbank       <= rbank_nxt;
      wcnt        <= wcnt_nxt;
      if (wr_fire && wr_first) begin
        bank_len[wbank] <= new_len;
        if (len_bad) o_len_err <= 1'b1;
      end
      o_wblk_done <= wr_fire && wr_last;
      o_rsc1_vld  <= rd_en1;
      o_rsc2_vld  <= rd_en2;
    end
  end

  assign waddr  = {wbank, wcnt};
  assign raddr1 = {rbank, i_raddr1};
  assign raddr2 = {rbank, i_raddr2};

  // Each read port gets its own copy so both can read any address every cycle.
  ccsds_turbo_sdpram #(.DEPTH(2 * K_MAX), .DW(DW)) u_ram_rsc1 (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_fire),
    .waddr (waddr),
    .wdata (i_wdata),
    .re    (rd_en1),
    .raddr (raddr1),
    .rdata (o_rsc1_idata)
  );

  ccsds_turbo_sdpram #(.DEPTH(2 * K_MAX), .DW(DW)) u_ram_rsc2 (
    .clk   (clk),
    .rstn  (rstn),
    .we    (wr_fire),
    .waddr (waddr),
    .wdata (i_wdata),
    .re    (rd_en2),
    .raddr (raddr2),
    .rdata (o_rsc2_idata)
  );

endmodule

// File: tb/tb_ccsds_turbo_enc_pingpong_buf.sv
// Bench for the ping-pong info-bit buffer: a bank-level behavioural model is
// compared every cycle, and directed steps pin literal values of that model.
module tb_ccsds_turbo_enc_pingpong_buf;

  localparam int K_MAX   = 16384;
  localparam int DW      = 1;
  localparam int AW      = $clog2(K_MAX);
  localparam int S_EMPTY = 0;
  localparam int S_FILL  = 1;
  localparam int S_FULL  = 2;
  localparam int S_READ  = 3;

  logic          clk = 1'b0;
  logic          rstn;
  logic [AW:0]   i_blk_len;
  logic          i_wvalid;
  logic [DW-1:0] i_wdata;
  logic          o_wready;
  logic          o_wblk_done;
  logic          o_rd_avail;
  logic          i_rd_start;
  logic [AW:0]   o_rd_len;
  logic          i_read1;
  logic [AW-1:0] i_raddr1;
  logic          i_read2;
  logic [AW-1:0] i_raddr2;
  logic [DW-1:0] o_rsc1_idata;
  logic          o_rsc1_vld;
  logic [DW-1:0] o_rsc2_idata;
  logic          o_rsc2_vld;
  logic          i_rd_done;
  logic          o_len_err;

  always #5 clk = ~clk;

  ccsds_turbo_enc_pingpong_buf #(.K_MAX(K_MAX), .DW(DW)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .i_blk_len    (i_blk_len),
    .i_wvalid     (i_wvalid),
    .i_wdata      (i_wdata),
    .o_wready     (o_wready),
    .o_wblk_done  (o_wblk_done),
    .o_rd_avail   (o_rd_avail),
    .i_rd_start   (i_rd_start),
    .o_rd_len     (o_rd_len),
    .i_read1      (i_read1),
    .i_raddr1     (i_raddr1),
    .i_read2      (i_read2),
    .i_raddr2     (i_raddr2),
    .o_rsc1_idata (o_rsc1_idata),
    .o_rsc1_vld   (o_rsc1_vld),
    .o_rsc2_idata (o_rsc2_idata),
    .o_rsc2_vld   (o_rsc2_vld),
    .i_rd_done    (i_rd_done),
    .o_len_err    (o_len_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic checkOutput(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: per-bank status, the block length and the bits received
  // for each bank, plus the last value each read port should be showing.
  int            m_st  [2];
  int            m_len [2];
  bit            m_wb, m_rb;
  logic [DW-1:0] m_q0 [$];
  logic [DW-1:0] m_q1 [$];
  bit            m_err, m_done, m_v1, m_v2, m_k1, m_k2;
  logic [DW-1:0] m_d1, m_d2;
  bit            model_ok = 1'b0;

  function automatic bit exp_wready();
    return (m_st[m_wb] == S_EMPTY) || (m_st[m_wb] == S_FILL);
  endfunction

  function automatic bit any_reading();
    return (m_st[0] == S_READ) || (m_st[1] == S_READ);
  endfunction

  function automatic bit exp_avail();
    return (m_st[m_rb] == S_FULL) && !any_reading();
  endfunction

  function automatic int exp_len();
    for (int b = 0; b < 2; b++)
      if (m_st[b] == S_READ) return m_len[b];
    return 0;
  endfunction

  function automatic logic [DW-1:0] bank_word(input bit b, input int a);
    return b ? m_q1[a] : m_q0[a];
  endfunction

  always @(posedge clk) begin
    if (!rstn) begin
      m_st[0]  = S_EMPTY;
      m_st[1]  = S_EMPTY;
      m_len[0] = 0;
      m_len[1] = 0;
      m_wb     = 1'b0;
      m_rb     = 1'b0;
      m_q0.delete();
      m_q1.delete();
      m_err    = 1'b0;
      m_done   = 1'b0;
      m_v1     = 1'b0;
      m_v2     = 1'b0;
      m_d1     = '0;
      m_d2     = '0;
      m_k1     = 1'b1;
      m_k2     = 1'b1;
      model_ok = 1'b1;
    end else if (model_ok) begin
      bit wr, claim, rel, rdng;
      int k, cnt;
      rdng  = any_reading();
      wr    = i_wvalid && exp_wready();
      claim = i_rd_start && exp_avail();
      rel   = i_rd_done && rdng;
      m_v1  = i_read1 && rdng;
      m_v2  = i_read2 && rdng;
      if (m_v1) begin
        m_k1 = (int'(i_raddr1) < m_len[m_rb]);
        if (m_k1) m_d1 = bank_word(m_rb, int'(i_raddr1));
      end
      if (m_v2) begin
        m_k2 = (int'(i_raddr2) < m_len[m_rb]);
        if (m_k2) m_d2 = bank_word(m_rb, int'(i_raddr2));
      end
      m_done = 1'b0;
      if (wr) begin
        if (m_st[m_wb] == S_EMPTY) begin
          k = int'(i_blk_len);
          if (k == 0 || k > K_MAX) begin
            k     = K_MAX;
            m_err = 1'b1;
          end
          m_len[m_wb] = k;
          m_st[m_wb]  = S_FILL;
          if (m_wb) m_q1.delete();
          else      m_q0.delete();
        end
        if (m_wb) m_q1.push_back(i_wdata);
        else      m_q0.push_back(i_wdata);
        cnt = m_wb ? m_q1.size() : m_q0.size();
        if (cnt == m_len[m_wb]) begin
          m_st[m_wb] = S_FULL;
          m_done     = 1'b1;
          m_wb       = !m_wb;
        end
      end
      if (claim) m_st[m_rb] = S_READ;
      if (rel) begin
        m_st[m_rb] = S_EMPTY;
        m_rb       = !m_rb;
      end
    end
  end

  // Every output is a function of registered state, so sampling on the
  // falling edge sees settled values.
  always @(negedge clk) begin
    if (model_ok) begin
      checkOutput("wready",    int'(o_wready),    int'(exp_wready()));
      checkOutput("rd_avail",  int'(o_rd_avail),  int'(exp_avail()));
      checkOutput("rd_len",    int'(o_rd_len),    exp_len());
      checkOutput("wblk_done", int'(o_wblk_done), int'(m_done));
      checkOutput("len_err",   int'(o_len_err),   int'(m_err));
      checkOutput("rsc1_vld",  int'(o_rsc1_vld),  int'(m_v1));
      checkOutput("rsc2_vld",  int'(o_rsc2_vld),  int'(m_v2));
      if (m_k1) checkOutput("rsc1_idata", int'(o_rsc1_idata), int'(m_d1));
      if (m_k2) checkOutput("rsc2_idata", int'(o_rsc2_idata), int'(m_d2));
    end
  end

  task automatic applyStimulus(input bit wv, input bit wd, input int len,
                               input bit rs, input bit rdn,
                               input bit r1, input int a1,
                               input bit r2, input int a2);
    i_wvalid   = wv;
    i_wdata    = DW'(wd);
    i_blk_len  = (AW+1)'(len);
    i_rd_start = rs;
    i_rd_done  = rdn;
    i_read1    = r1;
    i_raddr1   = AW'(a1);
    i_read2    = r2;
    i_raddr2   = AW'(a2);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int c = 0; c < n; c++) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Holds the write until the buffer accepts it, within a cycle budget.
  task automatic writeBit(input bit d, input int len);
    int budget;
    budget = 64;
    while (!o_wready && budget > 0) begin
      applyStimulus(1, d, len, 0, 0, 0, 0, 0, 0);
      budget--;
    end
    if (!o_wready) checkOutput("write_timeout", 0, 1);
    else           applyStimulus(1, d, len, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic randomTraffic(input int ncyc, input int maxlen);
    for (int c = 0; c < ncyc; c++)
      applyStimulus(($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                    int'($urandom_range(1, maxlen)),
                    ($urandom_range(0, 5) == 0), ($urandom_range(0, 11) == 0),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, maxlen + 3)),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, maxlen + 3)));
  endtask

  bit pat   [8] = '{1, 0, 1, 1, 0, 0, 1, 1};
  bit blk_b [8];
  int iaddr [4] = '{7, 3, 5, 1};

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    idle(2);
    checkOutput("reset_wready",   int'(o_wready),   1);
    checkOutput("reset_rd_avail", int'(o_rd_avail), 0);
    checkOutput("reset_rd_len",   int'(o_rd_len),   0);
    checkOutput("reset_len_err",  int'(o_len_err),  0);
    rstn = 1'b1;
    idle(1);

    // Reads and claims with nothing to read are ignored.
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 0, 0);
    checkOutput("idle_rsc1_vld", int'(o_rsc1_vld), 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    idle(1);
    checkOutput("idle_start_rd_len", int'(o_rd_len), 0);

    // K=8 block 10110011 then read it back in natural order.
    for (int i = 0; i < 8; i++) begin
      writeBit(pat[i], 8);
      if (i == 6) checkOutput("t1_done_early", int'(o_wblk_done), 0);
    end
    checkOutput("t1_wblk_done", int'(o_wblk_done), 1);
    checkOutput("t1_rd_avail",  int'(o_rd_avail),  1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("t1_rd_len", int'(o_rd_len), 8);
    for (int a = 0; a < 8; a++) begin
      applyStimulus(0, 0, 0, 0, 0, 1, a, 0, 0);
      checkOutput("t1_rsc1_vld",   int'(o_rsc1_vld),   1);
      checkOutput("t1_rsc1_idata", int'(o_rsc1_idata), int'(pat[a]));
    end
    idle(1);
    checkOutput("t1_vld_drop",  int'(o_rsc1_vld),   0);
    checkOutput("t1_data_hold", int'(o_rsc1_idata), int'(pat[7]));
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("t1_released_len", int'(o_rd_len), 0);

    // Two blocks back to back with no reads: the 17th write must stall.
    for (int i = 0; i < 8; i++) writeBit(1'($urandom_range(0, 1)), 8);
    for (int i = 0; i < 8; i++) begin
      blk_b[i] = 1'($urandom_range(0, 1));
      writeBit(blk_b[i], 8);
    end
    checkOutput("t2_wready_full", int'(o_wready),   0);
    checkOutput("t2_rd_avail",    int'(o_rd_avail), 1);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1, 1, 8, 0, 0, 0, 0, 0, 0);
      checkOutput("t2_stall", int'(o_wready), 0);
    end
    applyStimulus(1, 1, 8, 1, 0, 0, 0, 0, 0);
    checkOutput("t2_claim_len", int'(o_rd_len), 8);
    checkOutput("t2_stall_rd",  int'(o_wready), 0);
    applyStimulus(1, 1, 8, 0, 1, 0, 0, 0, 0);
    checkOutput("t2_wready_freed", int'(o_wready),   1);
    checkOutput("t2_next_avail",   int'(o_rd_avail), 1);

    // Interleaved reads of the full bank while the other one fills.
    applyStimulus(1, 1, 8, 1, 0, 0, 0, 0, 0);
    checkOutput("t3_rd_len", int'(o_rd_len), 8);
    for (int j = 0; j < 4; j++) begin
      applyStimulus(1, 1'($urandom_range(0, 1)), 8, 0, 0, 0, 0, 1, iaddr[j]);
      checkOutput("t3_rsc2_vld",   int'(o_rsc2_vld),   1);
      checkOutput("t3_rsc2_idata", int'(o_rsc2_idata), int'(blk_b[iaddr[j]]));
    end
    for (int i = 0; i < 3; i++) writeBit(1'($urandom_range(0, 1)), 8);
    checkOutput("t3_wblk_done",     int'(o_wblk_done), 1);
    checkOutput("t3_avail_blocked", int'(o_rd_avail),  0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);
    checkOutput("t3_avail_after_done", int'(o_rd_avail), 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    for (int a = 0; a < 8; a++) applyStimulus(0, 0, 0, 0, 0, 1, a, 1, 7 - a);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);

    randomTraffic(1000, 12);

    // Illegal length falls back to K_MAX and flags a sticky error.
    rstn = 1'b0;
    idle(2);
    rstn = 1'b1;
    writeBit(1'($urandom_range(0, 1)), 0);
    checkOutput("t4_len_err", int'(o_len_err), 1);
    for (int i = 1; i < K_MAX; i++) writeBit(1'($urandom_range(0, 1)), 5);
    checkOutput("t4_wblk_done", int'(o_wblk_done), 1);
    checkOutput("t4_len_err_sticky", int'(o_len_err), 1);
    applyStimulus(0, 0, 0, 1, 0, 0, 0, 0, 0);
    checkOutput("t4_rd_len", int'(o_rd_len), K_MAX);
    applyStimulus(0, 0, 0, 0, 0, 1, K_MAX - 1, 1, 0);
    applyStimulus(0, 0, 0, 0, 1, 0, 0, 0, 0);

    // Reset in the middle of a block discards it.
    for (int i = 0; i < 5; i++) writeBit(1'($urandom_range(0, 1)), 8);
    rstn = 1'b0;
    idle(1);
    checkOutput("t5_wready",   int'(o_wready),   1);
    checkOutput("t5_rd_avail", int'(o_rd_avail), 0);
    checkOutput("t5_len_err",  int'(o_len_err),  0);
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) writeBit(1'($urandom_range(0, 1)), 4);
    checkOutput("t5_done_early", int'(o_wblk_done), 0);
    writeBit(1'($urandom_range(0, 1)), 4);
    checkOutput("t5_wblk_done", int'(o_wblk_done), 1);
    checkOutput("t5_rd_avail_after", int'(o_rd_avail), 1);

    randomTraffic(500, 6);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ccsds_turbo_enc_pingpong_buf.md
Name: ccsds_turbo_enc_pingpong_buf

Overview:
- Parametrised, double-buffered (ping-pong) information-bit buffer for the CCSDS turbo encoder.
- Write side accepts a serial info stream with a valid/ready handshake and generates addresses internally.
- Read side serves two independent random-access read ports: RSC1 (natural order) and RSC2 (interleaver address) from one completed bank, while the other bank fills.
- Sits between the frame input stage and the two RSC encoders.

Parameters:
- K_MAX, 16384, maximum info block length in bits (per bank).
- DW, 1, data word width per address.
- AW, $clog2(K_MAX), local (derived) address width; not overridable.

Ports:
- clk  in  1  system clock.
- rstn  in  1  synchronous active-low reset.
- i_blk_len  in  AW+1  block length K; sampled on the first accepted write of each block.
- i_wvalid  in  1  write data valid.
- i_wdata  in  DW  write data.
- o_wready  out  1  write bank available (FILLING or claimable EMPTY).
- o_wblk_done  out  1  one-cycle pulse; last bit of a block was written.
- o_rd_avail  out  1  a FULL bank is waiting to be claimed.
- i_rd_start  in  1  pulse; claim the oldest FULL bank for reading.
- o_rd_len  out  AW+1  K of the bank in READING (0 when none).
- i_read1  in  1  RSC1 read enable.
- i_raddr1  in  AW  RSC1 address.
- i_read2  in  1  RSC2 read enable.
- i_raddr2  in  AW  RSC2 (interleaved) address.
- o_rsc1_idata  out  DW  RSC1 read data.
- o_rsc1_vld  out  1  RSC1 read data valid.
- o_rsc2_idata  out  DW  RSC2 read data.
- o_rsc2_vld  out  1  RSC2 read data valid.
- i_rd_done  in  1  pulse; release the READING bank.
- o_len_err  out  1  sticky; illegal i_blk_len seen.

Behaviour:
- Per-bank state: EMPTY -> FILLING -> FULL -> READING -> EMPTY. Two banks; bank index = MSB of physical address.
- Reset (rstn=0 at a clk edge): both banks EMPTY, wbank=0, rbank=0, write counter=0. All outputs 0 except o_wready=1 (asserts the cycle after reset releases). Reset mid-block discards all content.
- Write:
  - Transfer occurs when i_wvalid && o_wready.
  - On the first transfer, latch K = i_blk_len; if K==0 or K>K_MAX, use K=K_MAX and set o_len_err. The bank goes FILLING.
  - Data goes to address {wbank, wcnt}; wcnt increments per transfer.
  - On transfer with wcnt==K-1: bank goes FULL, o_wblk_done pulses that cycle (registered: visible the next cycle), wcnt=0, wbank toggles.
  - o_wready=0 while the write bank is FULL or READING. A write blocked at a block boundary resumes only when the other bank frees.
- Read claim:
  - o_rd_avail=1 when bank rbank is FULL and no bank is READING.
  - i_rd_start while o_rd_avail: bank becomes READING and o_rd_len=K of that bank, next cycle.
  - i_rd_start without o_rd_avail is ignored.
- Read ports:
  - Each read port has 1-cycle registered latency: data for the address presented at edge n appears after edge n+1, with o_rscX_vld=1.
  - o_rscX_vld=1 only if i_readX was high and a bank was READING at edge n.
  - Addresses >= K return undefined data, but vld behaves as above.
  - Both ports may read the same address in the same cycle.
  - Data out holds its last value when vld=0.
- Release:
  - i_rd_done while READING: bank goes EMPTY and rbank toggles next cycle.
  - i_rd_done and i_rd_start in the same cycle: done takes effect first; start is evaluated against the post-done state one cycle later, so the user must re-pulse.
- Simultaneous write-complete and rd_done on different banks are both honoured in the same cycle.
- The final write into a bank that is being released is impossible: a bank is never FILLING and READING at once.
- Storage: two identical memories of 2*K_MAX x DW, one per read port, both written on every transfer.

Decomposition:
- Package ccsds_turbo_enc_pkg:
  - bank-state enum (EMPTY, FILLING, FULL, READING).
  - K_MAX default.
  - clog2-based width constants.
- Sub-module ccsds_turbo_sdpram: simple dual-port RAM, 1 write / 1 registered read, parameters DEPTH and DW, inferable as block RAM. Instantiated twice.

Test Plan:
- Reset then write K=8 bits 10110011 continuously -> o_wblk_done pulse after the 8th transfer; o_rd_avail=1; i_rd_start -> o_rd_len=8; read1 addr 0..7 -> 1,0,1,1,0,0,1,1 with vld, 1-cycle latency.
- Write two K=8 blocks back-to-back with no reads -> o_wready=0 after the 16th transfer; a 17th i_wvalid stalls until i_rd_done of bank 0 releases it.
- Concurrent operation: read bank 0 via port2 with interleaved addresses 7,3,5,1 while filling bank 1 -> data matches bank 0 content at those addresses; bank 1 writes are unaffected.
- i_blk_len=0 on first write -> o_len_err=1 sticky; block completes after 16384 transfers.
- Assert rstn=0 after 5 of 8 writes -> next cycle o_wready=1 and o_rd_avail=0; a new K=4 block completes after exactly 4 transfers.
- i_read1 with no bank READING -> o_rsc1_vld stays 0; i_rd_start while o_rd_avail=0 is ignored.
